muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small op-class decoders used by the datapath.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iterative(input op_e op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input op_e op);
        case (op)
            OP_MULT, OP_DIV: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic is_divide(input op_e op);
        case (op)
            OP_DIV, OP_DIVU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline datapath (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int N = 64
);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] srca;
    logic [N-1:0] srcb;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, srca, srcb, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers. Signed ops run
// on magnitudes; one N+1-bit adder/subtractor is shared by both step kinds.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int N = 64
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(N);

    state_e         state_r;
    state_e         state_nxt_s;
    logic           busy_r;
    logic           done_r;
    logic           busy_nxt_s;
    logic           done_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   acc_r;
    logic [N-1:0]   mq_r;
    logic [N-1:0]   mcand_r;
    logic           is_div_r;
    logic           neg_lo_r;
    logic           neg_hi_r;
    logic [N-1:0]   hi_r;
    logic [N-1:0]   lo_r;

    op_e            op_s;
    logic           accept_s;
    logic           start_iter_s;
    logic           step_en_s;
    logic           last_step_s;
    logic           sign_a_s;
    logic           sign_b_s;
    logic           neg_lo_nxt_s;
    logic           neg_hi_nxt_s;
    logic [N-1:0]   mag_a_s;
    logic [N-1:0]   mag_b_s;
    logic [N:0]     add_a_s;
    logic [N:0]     add_b_s;
    logic [N:0]     add_sum_s;
    logic [N:0]     mul_sel_s;
    logic           q_bit_s;
    logic [N-1:0]   step_acc_s;
    logic [N-1:0]   step_mq_s;
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   res_hi_s;
    logic [N-1:0]   res_lo_s;

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return ~v + {{(2*N-1){1'b0}}, 1'b1};
    endfunction

    // Request qualification: flush always beats start, RUN ignores start
    always_comb begin
        op_s     = op_e'(bus.op);
        accept_s = 1'b0;
        if (bus.start && !bus.flush && (state_r == ST_IDLE || state_r == ST_DONE)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        start_iter_s = accept_s && is_iterative(op_s);
        step_en_s    = (state_r == ST_RUN) && !bus.flush;
        last_step_s  = step_en_s && (cnt_r == {CW{1'b0}});
    end

    // Operand magnitudes and result signs captured when an iterative op starts
    always_comb begin
        sign_a_s = is_signed_op(op_s) & bus.srca[N-1];
        sign_b_s = is_signed_op(op_s) & bus.srcb[N-1];
        if (sign_a_s) mag_a_s = neg_n(bus.srca);
        else          mag_a_s = bus.srca;
        if (sign_b_s) mag_b_s = neg_n(bus.srcb);
        else          mag_b_s = bus.srcb;
        // Divide by zero keeps an all-ones quotient regardless of dividend sign
        if (is_divide(op_s)) begin
            neg_lo_nxt_s = (sign_a_s ^ sign_b_s) & (bus.srcb != {N{1'b0}});
            neg_hi_nxt_s = sign_a_s;
        end else begin
            neg_lo_nxt_s = sign_a_s ^ sign_b_s;
            neg_hi_nxt_s = sign_a_s ^ sign_b_s;
        end
    end

    // One shift-add or restoring-subtract step through the shared adder
    always_comb begin
        if (is_div_r) add_a_s = {acc_r, mq_r[N-1]};
        else          add_a_s = {1'b0, acc_r};
        add_b_s   = {1'b0, mcand_r};
        add_sum_s = add_a_s + (is_div_r ? ~add_b_s : add_b_s) + {{N{1'b0}}, is_div_r};
        mul_sel_s = {(N+1){1'b0}};
        q_bit_s   = 1'b0;
        if (is_div_r) begin
            if (add_sum_s[N]) begin
                step_acc_s = add_a_s[N-1:0];
                q_bit_s    = 1'b0;
            end else begin
                step_acc_s = add_sum_s[N-1:0];
                q_bit_s    = 1'b1;
            end
            step_mq_s = {mq_r[N-2:0], q_bit_s};
        end else begin
            if (mq_r[0]) mul_sel_s = add_sum_s;
            else         mul_sel_s = add_a_s;
            step_acc_s = mul_sel_s[N:1];
            step_mq_s  = {mul_sel_s[0], mq_r[N-1:1]};
        end
    end

    // Sign restoration of the final step's values into HI/LO results
    always_comb begin
        prod_s = {step_acc_s, step_mq_s};
        if (is_div_r) begin
            if (neg_lo_r) res_lo_s = neg_n(step_mq_s);
            else          res_lo_s = step_mq_s;
            if (neg_hi_r) res_hi_s = neg_n(step_acc_s);
            else          res_hi_s = step_acc_s;
        end else begin
            if (neg_lo_r) prod_s = neg_2n({step_acc_s, step_mq_s});
            else          prod_s = {step_acc_s, step_mq_s};
            res_hi_s = prod_s[2*N-1:N];
            res_lo_s = prod_s[N-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_iter_s) state_nxt_s = ST_RUN;
                else              state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.flush)                      state_nxt_s = ST_IDLE;
                else if (cnt_r == {CW{1'b0}})       state_nxt_s = ST_DONE;
                else                                state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (start_iter_s) state_nxt_s = ST_RUN;
                else              state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so busy/done leave flops
    always_comb begin
        if (state_nxt_s == ST_RUN)  busy_nxt_s = 1'b1;
        else                        busy_nxt_s = 1'b0;
        if (state_nxt_s == ST_DONE) done_nxt_s = 1'b1;
        else                        done_nxt_s = 1'b0;
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Iteration counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    cnt_r <= {CW{1'b0}};
        else if (start_iter_s)                        cnt_r <= CW'(N - 1);
        else if (step_en_s && cnt_r != {CW{1'b0}})    cnt_r <= cnt_r - CW'(1);
    end

    // Working registers: multiplier/quotient shifter, accumulator, operand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r    <= {N{1'b0}};
            mq_r     <= {N{1'b0}};
            mcand_r  <= {N{1'b0}};
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
        end else if (start_iter_s) begin
            acc_r    <= {N{1'b0}};
            is_div_r <= is_divide(op_s);
            neg_lo_r <= neg_lo_nxt_s;
            neg_hi_r <= neg_hi_nxt_s;
            if (is_divide(op_s)) begin
                mq_r    <= mag_a_s;
                mcand_r <= mag_b_s;
            end else begin
                mq_r    <= mag_b_s;
                mcand_r <= mag_a_s;
            end
        end else if (step_en_s) begin
            acc_r <= step_acc_s;
            mq_r  <= step_mq_s;
        end
    end

    // HI/LO: written by a completing op or by MTHI/MTLO only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= {N{1'b0}};
            lo_r <= {N{1'b0}};
        end else if (last_step_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (accept_s && op_s == OP_MTHI) begin
            hi_r <= bus.srca;
        end else if (accept_s && op_s == OP_MTLO) begin
            lo_r <= bus.srca;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// corner sequences and random ops against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, RSV6 = 3'd6;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.N(32)) if32 ();
    muldiv_unit_if #(.N(64)) if64 ();

    muldiv_unit #(.N(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    muldiv_unit #(.N(64)) dut64 (.clk(clk), .reset(reset), .bus(if64));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'h0;
        l = 32'h0;
        case (op)
            MULT:  begin p = sa * sb; {h, l} = p; end
            MULTU: begin up = {32'h0, a} * {32'h0, b}; {h, l} = up; end
            DIV: begin
                if (b == 32'h0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = 32'(sa / sb); h = 32'(sa % sb); end
            end
            DIVU: begin
                if (b == 32'h0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = a / b; h = a % b; end
            end
            default: begin h = 32'h0; l = 32'h0; end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic runIter32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int nBusy);
        if32.start = 1'b1; if32.op = op; if32.srca = a; if32.srcb = b;
        tick();
        if32.start = 1'b0;
        nBusy = 0;
        while (if32.busy === 1'b1 && nBusy < BUDGET) begin
            nBusy++;
            tick();
        end
    endtask

    task automatic simple32(input logic [2:0] op, input logic [31:0] a, input logic flush);
        if32.start = 1'b1; if32.op = op; if32.srca = a; if32.srcb = 32'h0; if32.flush = flush;
        tick();
        if32.start = 1'b0; if32.flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nb2;
        logic [31:0] mhi, mlo, a, b, eh, el;
        logic [2:0] op;
        logic sawDone;

        vecs[0] = '{"mult_neg3x5",    MULT,  32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{"div_7_by_m2",    DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
        vecs[2] = '{"divu_7_by_0",    DIVU,  32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF};
        vecs[3] = '{"multu_max_sq",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1};
        vecs[4] = '{"div_min_by_m1",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5] = '{"divu_100_by_7",  DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6] = '{"div_m7_by_2",    DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[7] = '{"div_m7_by_0",    DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[8] = '{"mult_min_sq",    MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[9] = '{"mult_7_by_m1",   MULT,  32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

        if32.start = 1'b0; if32.op = 3'd0; if32.srca = 32'h0; if32.srcb = 32'h0; if32.flush = 1'b0;
        if64.start = 1'b0; if64.op = 3'd0; if64.srca = 64'h0; if64.srcb = 64'h0; if64.flush = 1'b0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check("reset_busy", {63'h0, if32.busy}, 64'h0);
        check("reset_done", {63'h0, if32.done}, 64'h0);
        check("reset_hi", {32'h0, if32.hi}, 64'h0);
        check("reset_lo", {32'h0, if32.lo}, 64'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            runIter32(vecs[i].op, vecs[i].a, vecs[i].b, nb);
            check({vecs[i].name, "_busycycles"}, 64'(nb), 64'd32);
            check({vecs[i].name, "_done"}, {63'h0, if32.done}, 64'h1);
            check({vecs[i].name, "_hi"}, {32'h0, if32.hi}, {32'h0, vecs[i].expHi});
            check({vecs[i].name, "_lo"}, {32'h0, if32.lo}, {32'h0, vecs[i].expLo});
            tick();
            check({vecs[i].name, "_done_pulse"}, {63'h0, if32.done}, 64'h0);
        end

        // Back-to-back: new op accepted in the DONE cycle with no bubble
        runIter32(MULT, 32'd6, 32'd7, nb);
        check("b2b_first_lo", {32'h0, if32.lo}, 64'd42);
        runIter32(DIVU, 32'd100, 32'd7, nb2);
        check("b2b_second_busycycles", 64'(nb2), 64'd32);
        check("b2b_second_lo", {32'h0, if32.lo}, 64'd14);
        tick();

        // MULTU then MTLO issued in the DONE cycle
        runIter32(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
        check("mtlo_after_done_hi", {32'h0, if32.hi}, 64'hFFFF_FFFE);
        simple32(MTLO, 32'h55, 1'b0);
        check("mtlo_after_done_lo", {32'h0, if32.lo}, 64'h55);
        check("mtlo_after_done_hikeep", {32'h0, if32.hi}, 64'hFFFF_FFFE);
        check("mtlo_after_done_nodone", {63'h0, if32.done}, 64'h0);
        check("mtlo_after_done_nobusy", {63'h0, if32.busy}, 64'h0);

        // Flush in RUN at busy cycle 10
        simple32(MTHI, 32'h1111, 1'b0);
        simple32(MTLO, 32'h2222, 1'b0);
        check("mthi_value", {32'h0, if32.hi}, 64'h1111);
        if32.start = 1'b1; if32.op = MULT; if32.srca = 32'd3; if32.srcb = 32'd5;
        tick();
        if32.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("flush_busy_before", {63'h0, if32.busy}, 64'h1);
        if32.flush = 1'b1;
        tick();
        if32.flush = 1'b0;
        check("flush_busy_after", {63'h0, if32.busy}, 64'h0);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if32.done === 1'b1) sawDone = 1'b1;
            tick();
        end
        check("flush_no_done", {63'h0, sawDone}, 64'h0);
        check("flush_hi_kept", {32'h0, if32.hi}, 64'h1111);
        check("flush_lo_kept", {32'h0, if32.lo}, 64'h2222);

        // Start during RUN is ignored
        if32.start = 1'b1; if32.op = MULTU; if32.srca = 32'd6; if32.srcb = 32'd7;
        tick();
        nb = 0;
        while (if32.busy === 1'b1 && nb < BUDGET) begin
            if32.start = (nb == 4);
            if32.op = DIVU; if32.srca = 32'd1; if32.srcb = 32'd1;
            nb++;
            tick();
        end
        if32.start = 1'b0;
        check("run_start_ignored_busycycles", 64'(nb), 64'd32);
        check("run_start_ignored_lo", {32'h0, if32.lo}, 64'd42);
        tick();

        // Flush beats start in IDLE; reserved op changes nothing
        simple32(MTHI, 32'hDEAD, 1'b1);
        check("flush_start_mthi_dropped", {32'h0, if32.hi}, 64'h0);
        if32.start = 1'b1; if32.op = MULT; if32.srca = 32'd2; if32.srcb = 32'd2; if32.flush = 1'b1;
        tick();
        if32.start = 1'b0; if32.flush = 1'b0;
        check("flush_start_mult_dropped", {63'h0, if32.busy}, 64'h0);
        simple32(RSV6, 32'hBEEF, 1'b0);
        check("reserved_hi", {32'h0, if32.hi}, 64'h0);
        check("reserved_lo", {32'h0, if32.lo}, 64'd42);
        check("reserved_busy", {63'h0, if32.busy}, 64'h0);

        // Random ops against the reference model
        simple32(MTHI, 32'hA5A5_0001, 1'b0);
        simple32(MTLO, 32'h5A5A_0002, 1'b0);
        mhi = 32'hA5A5_0001;
        mlo = 32'h5A5A_0002;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (op <= DIVU) begin
                runIter32(op, a, b, nb);
                refModel(op, a, b, mhi, mlo);
                check("rand_busycycles", 64'(nb), 64'd32);
                check("rand_hi", {32'h0, if32.hi}, {32'h0, mhi});
                check("rand_lo", {32'h0, if32.lo}, {32'h0, mlo});
                tick();
            end else begin
                simple32(op, a, 1'b0);
                if (op == MTHI) mhi = a;
                else if (op == MTLO) mlo = a;
                check("rand_move_hi", {32'h0, if32.hi}, {32'h0, mhi});
                check("rand_move_lo", {32'h0, if32.lo}, {32'h0, mlo});
                check("rand_move_busy", {63'h0, if32.busy}, 64'h0);
                check("rand_move_done", {63'h0, if32.done}, 64'h0);
            end
        end

        // N=64 multiply and divide
        if64.start = 1'b1; if64.op = MULT;
        if64.srca = 64'h0000_0100_0000_0000; if64.srcb = 64'h0000_0000_4000_0000;
        tick();
        if64.start = 1'b0;
        nb = 0;
        while (if64.busy === 1'b1 && nb < BUDGET) begin nb++; tick(); end
        check("n64_mult_busycycles", 64'(nb), 64'd64);
        check("n64_mult_done", {63'h0, if64.done}, 64'h1);
        check("n64_mult_hi", if64.hi, 64'h40);
        check("n64_mult_lo", if64.lo, 64'h0);
        if64.start = 1'b1; if64.op = DIV;
        if64.srca = 64'h8000_0000_0000_0000; if64.srcb = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        if64.start = 1'b0;
        nb = 0;
        while (if64.busy === 1'b1 && nb < BUDGET) begin nb++; tick(); end
        check("n64_divmin_busycycles", 64'(nb), 64'd64);
        check("n64_divmin_lo", if64.lo, 64'h8000_0000_0000_0000);
        check("n64_divmin_hi", if64.hi, 64'h0);
        tick();

        // Asynchronous reset in the middle of a divide
        if32.start = 1'b1; if32.op = DIV; if32.srca = 32'h8000_0000; if32.srcb = 32'hFFFF_FFFF;
        tick();
        if32.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midrun_busy", {63'h0, if32.busy}, 64'h1);
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", {63'h0, if32.busy}, 64'h0);
        check("midrun_reset_done", {63'h0, if32.done}, 64'h0);
        check("midrun_reset_hi", {32'h0, if32.hi}, 64'h0);
        check("midrun_reset_lo", {32'h0, if32.lo}, 64'h0);
        check("midrun_reset_hi64", if64.hi, 64'h0);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("after_reset_busy", {63'h0, if32.busy}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
